// File: rtl/addn_seq.sv
// Chunk-serial WIDTH-bit adder/subtractor with a start/done handshake: CHUNK bits per clock.
// Optional subtract mode (sub port, x + ~y + 1) is enabled by defining ADDN_SEQ_SUB_EN.
module addn_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ADDN_SEQ_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_carry;
    logic [WIDTH-1:0] r_psum;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_ovf;

    logic [WIDTH-1:0] w_y_eff;
    logic             w_c_eff;
    logic [CHUNK:0]   w_sum_full;
    logic [WIDTH-1:0] w_psum_next;
    logic             w_last;
    logic             w_ovf;

`ifdef ADDN_SEQ_SUB_EN
    assign w_y_eff = sub ? ~y : y;
    assign w_c_eff = sub ? 1'b1 : c_in;
`else
    assign w_y_eff = y;
    assign w_c_eff = c_in;
`endif

    // Operands shift right each cycle, so the active chunk is always the low CHUNK bits.
    assign w_sum_full = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, r_carry};
    assign w_last     = (r_cnt == CW'(N - 1));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_psum
            assign w_psum_next[gi*CHUNK +: CHUNK] = (r_cnt == CW'(gi)) ? w_sum_full[CHUNK-1:0]
                                                                      : r_psum[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_ovf = (r_a_msb == r_b_msb) && (w_psum_next[WIDTH-1] != r_a_msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= x;
                        r_b     <= w_y_eff;
                        r_a_msb <= x[WIDTH-1];
                        r_b_msb <= w_y_eff[WIDTH-1];
                        r_carry <= w_c_eff;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_psum  <= w_psum_next;
                    r_carry <= w_sum_full[CHUNK];
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s     <= w_psum_next;
                        r_c_out <= w_sum_full[CHUNK];
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign s     = r_s;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_addn_seq.sv
// Directed bench for addn_seq: a 16/4 instance for the main vectors and corner sequences,
// plus a 16/16 instance for the single-cycle configuration.
module tb_addn_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start4, start16;
    logic [W-1:0] x, y;
    logic         c_in;
`ifdef ADDN_SEQ_SUB_EN
    logic         sub;
`endif

    logic         ready4, done4, c4, v4;
    logic [W-1:0] s4;
    logic         ready16, done16, c16, v16;
    logic [W-1:0] s16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    addn_seq #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
`ifdef ADDN_SEQ_SUB_EN
        .sub(sub),
`endif
        .x(x), .y(y), .c_in(c_in),
        .ready(ready4), .done(done4), .s(s4), .c_out(c4), .ovf(v4)
    );

    addn_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16),
`ifdef ADDN_SEQ_SUB_EN
        .sub(sub),
`endif
        .x(x), .y(y), .c_in(c_in),
        .ready(ready16), .done(done16), .s(s16), .c_out(c16), .ovf(v16)
    );

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic         sb;
        logic [W-1:0] es;
        logic         ec;
        logic         ev;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive operands with start high, let one rising edge sample them, then drop start.
    task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] yb,
                          input logic ci, input logic sb);
        x = xa; y = yb; c_in = ci;
`ifdef ADDN_SEQ_SUB_EN
        sub = sb;
`else
        if (sb) $display("[TB] sub requested without subtract support");
`endif
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
    endtask

    // Counts edges until done4 is seen; ready must stay low before that. 99 means timeout.
    task automatic wait_done4(output int lat, output logic rdy_ok);
        lat = 99;
        rdy_ok = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                lat = k;
                break;
            end
            if (ready4) rdy_ok = 1'b0;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int   lat;
        logic rok;
        @(negedge clk);
        launch(v.x, v.y, v.cin, v.sb);
        wait_done4(lat, rok);
        $display("[TB] %s x=%h y=%h cin=%b sub=%b -> s=%h c=%b v=%b lat=%0d",
                 name, v.x, v.y, v.cin, v.sb, s4, c4, v4, lat);
        check({name, " latency"}, lat, 4);
        check({name, " ready_low"}, {31'b0, rok}, 1);
        check({name, " ready_at_done"}, {31'b0, ready4}, 1);
        check({name, " s"}, {16'b0, s4}, {16'b0, v.es});
        check({name, " c_out"}, {31'b0, c4}, {31'b0, v.ec});
        check({name, " ovf"}, {31'b0, v4}, {31'b0, v.ev});
        @(posedge clk);
        #1;
        check({name, " done_pulse_end"}, {31'b0, done4}, 0);
    endtask

    vec_t add_vecs[7];
`ifdef ADDN_SEQ_SUB_EN
    vec_t sub_vecs[4];
`endif

    initial begin
        int   lat;
        logic rok;
        int   n_done;

        add_vecs[0] = '{16'h000F, 16'h0003, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0};
        add_vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        add_vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        add_vecs[3] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        add_vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        add_vecs[5] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
        add_vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
`ifdef ADDN_SEQ_SUB_EN
        sub_vecs[0] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        sub_vecs[1] = '{16'h0009, 16'h0002, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0};
        sub_vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        sub_vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        sub = 1'b0;
`endif

        rst = 1'b1; start4 = 1'b0; start16 = 1'b0;
        x = '0; y = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset: ready=%b done=%b s=%h c=%b v=%b", ready4, done4, s4, c4, v4);
        check("rst ready", {31'b0, ready4}, 1);
        check("rst done", {31'b0, done4}, 0);
        check("rst s", {16'b0, s4}, 0);
        check("rst c_out", {31'b0, c4}, 0);
        check("rst ovf", {31'b0, v4}, 0);
        check("rst ready16", {31'b0, ready16}, 1);

        for (int i = 0; i < 7; i++) run_vec($sformatf("add%0d", i), add_vecs[i]);
`ifdef ADDN_SEQ_SUB_EN
        for (int i = 0; i < 4; i++) run_vec($sformatf("sub%0d", i), sub_vecs[i]);
`endif

        // start pulsed one cycle into RUN must be ignored
        @(negedge clk);
        launch(16'h000F, 16'h0003, 1'b0, 1'b0);
        @(negedge clk);
        x = 16'hAAAA; y = 16'h5555; c_in = 1'b1; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done4(lat, rok);
        $display("[TB] ignore_start -> s=%h c=%b lat=%0d", s4, c4, lat);
        check("ignore latency", lat, 3);
        check("ignore s", {16'b0, s4}, 32'h0012);
        check("ignore c_out", {31'b0, c4}, 0);
        @(posedge clk);
        #1;
        check("ignore no_second_op", {31'b0, ready4}, 1);

        // leave nonzero s/c_out behind, then abort an operation with reset
        run_vec("pre_rst", '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0});
        @(negedge clk);
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] mid_rst -> ready=%b done=%b s=%h c=%b v=%b", ready4, done4, s4, c4, v4);
        check("midrst ready", {31'b0, ready4}, 1);
        check("midrst s", {16'b0, s4}, 0);
        check("midrst c_out", {31'b0, c4}, 0);
        check("midrst ovf", {31'b0, v4}, 0);
        check("midrst done", {31'b0, done4}, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done4) n_done++;
        end
        check("midrst no_done", n_done, 0);
        check("midrst s_held", {16'b0, s4}, 0);

        // back-to-back: second start issued in the done cycle
        @(negedge clk);
        launch(16'h0001, 16'h0002, 1'b0, 1'b0);
        wait_done4(lat, rok);
        $display("[TB] b2b first -> s=%h lat=%0d", s4, lat);
        check("b2b1 latency", lat, 4);
        check("b2b1 s", {16'b0, s4}, 32'h0003);
        launch(16'h0010, 16'h0020, 1'b0, 1'b0);
        wait_done4(lat, rok);
        $display("[TB] b2b second -> s=%h lat=%0d", s4, lat);
        check("b2b2 latency", lat, 4);
        check("b2b2 s", {16'b0, s4}, 32'h0030);

        // CHUNK == WIDTH: single-cycle latency
        @(negedge clk);
        x = 16'h1234; y = 16'h1111; c_in = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] chunk16 x=1234 y=1111 -> done=%b s=%h c=%b", done16, s16, c16);
        check("c16 done", {31'b0, done16}, 1);
        check("c16 s", {16'b0, s16}, 32'h2345);
        check("c16 c_out", {31'b0, c16}, 0);
        check("c16 ready", {31'b0, ready16}, 1);
        @(negedge clk);
        x = 16'hFFFF; y = 16'h0001; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] chunk16 x=FFFF y=0001 -> done=%b s=%h c=%b", done16, s16, c16);
        check("c16b done", {31'b0, done16}, 1);
        check("c16b s", {16'b0, s16}, 0);
        check("c16b c_out", {31'b0, c16}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
